hypot_seq_ctrl: RTL and testbench

- Sequencing controller for the hypotenuse datapath: computes sum_sq = x² + y² and result = floor(sqrt(sum_sq)).
- A single shared iterative shift-add squarer is time-multiplexed across three jobs: squaring x, squaring y, and every trial square of the bit-by-bit root search.
- Replaces the one-cycle loop-unrolled datapath with a start/busy/done handshake sitting between the tt_um top-level pins and the squarer.

---
 rtl/hypot_pkg.sv | 19 +
 rtl/hypot_sq_unit.sv | 63 ++++++
 rtl/hypot_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_hypot_seq_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hypot_pkg.sv
// Shared types and widths for the sequenced hypotenuse datapath.
// Controller states, derived widths and fixed latency.
package hypot_pkg;

    localparam int HW = 8;
    localparam int OPW = HW + 1;
    localparam int PRODW = 2 * HW + 2;
    localparam int SUMW = 2 * HW + 1;
    localparam int LAT = (HW + 3) * (HW + 2) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SQ_X,
        SQ_Y,
        ROOT,
        DONE
    } state_t;

endpackage

// File: rtl/hypot_sq_unit.sv
// Iterative shift-add squarer shared by all jobs of the controller.
// The load edge performs the first partial product; W more edges follow.
module hypot_sq_unit
    import hypot_pkg::*;
#(
    parameter int W = HW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           go,
    input  logic [W:0]     op,
    output logic           sq_done,
    output logic [2*W+1:0] prod
);

    localparam int OPW_L = W + 1;
    localparam int PRODW_L = 2 * W + 2;
    localparam int CW = $clog2(W + 1);

    logic                running;
    logic [CW-1:0]       cnt;
    logic [PRODW_L-1:0]  mcand;
    logic [OPW_L-1:0]    mplier;
    logic [PRODW_L-1:0]  op_ext;

    assign op_ext = PRODW_L'(op);

    // Load on go when idle, then shift-add until the multiplier is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            sq_done <= 1'b0;
        end else if (ena) begin
            sq_done <= 1'b0;
            if (!running) begin
                if (go) begin
                    running <= 1'b1;
                    mcand   <= op_ext << 1;
                    mplier  <= op >> 1;
                    prod    <= op[0] ? op_ext : '0;
                    cnt     <= CW'(W);
                end
            end else begin
                if (mplier[0]) begin
                    prod <= prod + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    sq_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hypot_seq_ctrl.sv
// Sequencing controller: x^2 + y^2 then a bit-by-bit integer root,
// all squares computed on one shared iterative squarer.
module hypot_seq_ctrl
    import hypot_pkg::*;
#(
    parameter int W = HW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           start,
    input  logic [W-1:0]   x_in,
    input  logic [W-1:0]   y_in,
    output logic           busy,
    output logic           done,
    output logic [W:0]     result,
    output logic [2*W:0]   sum_sq
);

    localparam int OPW_L = W + 1;
    localparam int PRODW_L = 2 * W + 2;
    localparam int SUMW_L = 2 * W + 1;
    localparam int BW = $clog2(W + 1);

    state_t               state;
    logic [W-1:0]         x_r;
    logic [W-1:0]         y_r;
    logic [SUMW_L-1:0]    acc;
    logic [OPW_L-1:0]     root;
    logic [BW-1:0]        b;
    logic                 go;
    logic                 kick;

    logic [OPW_L-1:0]     cand;
    logic [OPW_L-1:0]     op;
    logic [OPW_L-1:0]     root_nxt;
    logic                 fits;
    logic                 sq_done;
    logic [PRODW_L-1:0]   prod;

    assign cand = root | (OPW_L'(1) << b);
    assign fits = prod <= PRODW_L'(acc);
    assign root_nxt = fits ? cand : root;

    // Route the operand of the job currently owning the squarer.
    always_comb begin
        op = '0;
        unique case (state)
            SQ_X:    op = {1'b0, x_r};
            SQ_Y:    op = {1'b0, y_r};
            ROOT:    op = cand;
            default: op = '0;
        endcase
    end

    hypot_sq_unit #(
        .W(W)
    ) u_sq (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .go     (go),
        .op     (op),
        .sq_done(sq_done),
        .prod   (prod)
    );

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_r    <= '0;
            y_r    <= '0;
            acc    <= '0;
            root   <= '0;
            b      <= '0;
            go     <= 1'b0;
            kick   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            sum_sq <= '0;
        end else if (ena) begin
            go <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        acc   <= '0;
                        root  <= '0;
                        kick  <= 1'b1;
                        busy  <= 1'b1;
                        state <= SQ_X;
                    end
                end
                SQ_X: begin
                    if (kick) begin
                        go   <= 1'b1;
                        kick <= 1'b0;
                    end
                    if (sq_done) begin
                        acc   <= prod[SUMW_L-1:0];
                        go    <= 1'b1;
                        state <= SQ_Y;
                    end
                end
                SQ_Y: begin
                    if (sq_done) begin
                        acc   <= acc + prod[SUMW_L-1:0];
                        b     <= BW'(W);
                        go    <= 1'b1;
                        state <= ROOT;
                    end
                end
                ROOT: begin
                    if (sq_done) begin
                        root <= root_nxt;
                        if (b == '0) begin
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= root_nxt;
                            sum_sq <= acc;
                            state  <= DONE;
                        end else begin
                            b  <= b - BW'(1);
                            go <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        acc   <= '0;
                        root  <= '0;
                        kick  <= 1'b1;
                        busy  <= 1'b1;
                        state <= SQ_X;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hypot_seq_ctrl.sv
// Directed bench for hypot_seq_ctrl: latency, results, reset, ena, handshake.
// Expected values are hand-computed constants.
module tb_hypot_seq_ctrl;
    import hypot_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic        busy;
    logic        done;
    logic [8:0]  result;
    logic [16:0] sum_sq;

    int checks = 0;
    int errors = 0;

    hypot_seq_ctrl #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .result(result),
        .sum_sq(sum_sq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go_start(input logic [7:0] x, input logic [7:0] y);
        x_in = x;
        y_in = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int ena_at, input int restart_at,
                             output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= LAT + 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
            if (k == ena_at) ena = 1'b0;
            if (k == ena_at + 5) ena = 1'b1;
            if (k == restart_at) begin
                start = 1'b1;
                x_in = 8'd9;
                y_in = 8'd9;
            end
            if (k == restart_at + 1) begin
                start = 1'b0;
                x_in = 8'hff;
                y_in = 8'haa;
            end
        end
    endtask

    initial begin
        int lat;
        bit bok;
        bit saw_done;
        rst_n = 1'b0;
        ena = 1'b1;
        start = 1'b0;
        x_in = '0;
        y_in = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_sum_sq", sum_sq, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        go_start(8'd3, 8'd4);
        wait_done(0, 0, lat, bok);
        chk("t34_latency", lat, 111);
        chk("t34_busy_run", bok, 1);
        chk("t34_busy_at_done", busy, 0);
        chk("t34_sum_sq", sum_sq, 25);
        chk("t34_result", result, 5);
        @(posedge clk);
        #1;
        chk("t34_done_pulse", done, 0);
        chk("t34_idle_busy", busy, 0);
        chk("t34_hold_result", result, 5);

        go_start(8'd255, 8'd255);
        wait_done(0, 0, lat, bok);
        chk("tmax_latency", lat, 111);
        chk("tmax_sum_sq", sum_sq, 130050);
        chk("tmax_result", result, 360);

        go_start(8'd0, 8'd0);
        wait_done(0, 0, lat, bok);
        chk("t00_latency", lat, 111);
        chk("t00_sum_sq", sum_sq, 0);
        chk("t00_result", result, 0);
        go_start(8'd1, 8'd0);
        wait_done(0, 0, lat, bok);
        chk("tb2b_latency", lat, 111);
        chk("tb2b_busy_run", bok, 1);
        chk("tb2b_sum_sq", sum_sq, 1);
        chk("tb2b_result", result, 1);

        go_start(8'd6, 8'd8);
        wait_done(0, 20, lat, bok);
        chk("tign_latency", lat, 111);
        chk("tign_sum_sq", sum_sq, 100);
        chk("tign_result", result, 10);
        @(posedge clk);
        #1;
        chk("tign_no_requeue", busy, 0);

        go_start(8'd20, 8'd21);
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("trst_busy", busy, 0);
        chk("trst_done", done, 0);
        chk("trst_result", result, 0);
        chk("trst_sum_sq", sum_sq, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        chk("trst_quiet", saw_done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        go_start(8'd7, 8'd24);
        wait_done(0, 0, lat, bok);
        chk("trst_re_latency", lat, 111);
        chk("trst_re_sum_sq", sum_sq, 625);
        chk("trst_re_result", result, 25);

        go_start(8'd5, 8'd12);
        wait_done(30, 0, lat, bok);
        chk("tena_latency", lat, 116);
        chk("tena_sum_sq", sum_sq, 169);
        chk("tena_result", result, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
